// File: rtl/ac_pkg.sv
// ----------------------------------------------------------------------------
// ac_pkg : shared types and default widths for the access-control data paths
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package ac_pkg;

  localparam int AC_UPSP_DATA_WIDTH = 32;
  localparam int AC_AXIS_DATA_WIDTH = 128;
  localparam int AC_FIFO_DEPTH      = 8;
  localparam int AC_GEOM_WIDTH      = 16;

  typedef enum logic [1:0] {
    AC_OUT_IDLE  = 2'd0,
    AC_OUT_RUN   = 2'd1,
    AC_OUT_DRAIN = 2'd2
  } ac_out_state_e;

  // Beat layout at the default stream width; parametrised users mirror it.
  typedef struct packed {
    logic [AC_AXIS_DATA_WIDTH-1:0]   data;
    logic [AC_AXIS_DATA_WIDTH/8-1:0] keep;
    logic                            last;
    logic                            user;
  } ac_beat_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int ac_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ac_axis_out_packer_if.sv
// ----------------------------------------------------------------------------
// ac_axis_out_packer_if : pixel write port plus AXI-Stream master bundle
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface ac_axis_out_packer_if #(
  parameter int UPSP_DATA_WIDTH = 32,
  parameter int AXIS_DATA_WIDTH = 128
);
  logic                         upsp_ac_wrt;
  logic [UPSP_DATA_WIDTH-1:0]   upsp_ac_wdata;
  logic                         ac_upsp_wready;
  logic                         axis_tvalid;
  logic                         axis_tready;
  logic [AXIS_DATA_WIDTH-1:0]   axis_tdata;
  logic [AXIS_DATA_WIDTH/8-1:0] axis_tkeep;
  logic                         axis_tlast;
  logic                         axis_user;

  // Packer side: consumes pixels, drives the stream.
  modport master (
    input  upsp_ac_wrt, upsp_ac_wdata, axis_tready,
    output ac_upsp_wready, axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_user
  );

  // Environment side: produces pixels, sinks the stream.
  modport slave (
    output upsp_ac_wrt, upsp_ac_wdata, axis_tready,
    input  ac_upsp_wready, axis_tvalid, axis_tdata, axis_tkeep, axis_tlast, axis_user
  );
endinterface

`default_nettype wire

// File: rtl/ac_sync_fifo.sv
// ----------------------------------------------------------------------------
// ac_sync_fifo : first-word fall-through synchronous FIFO with occupancy count
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ac_sync_fifo
  import ac_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = ac_idx_width(DEPTH)
) (
  input  wire              clk,
  input  wire              rst_n,
  input  wire              i_push,
  input  wire  [WIDTH-1:0] i_data,
  input  wire              i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam int            CW     = AW + 1;
  localparam logic [AW:0]   C_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = i_push && (r_count != C_FULL);
  assign w_rd = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == C_FULL);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule

`default_nettype wire

// File: rtl/ac_axis_out_packer.sv
// ----------------------------------------------------------------------------
// ac_axis_out_packer : packs pixels into framed AXI-Stream beats via a FIFO.
// Optional AC_OUT_STALL_CNT_EN adds a saturating stall_cnt output.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module ac_axis_out_packer
  import ac_pkg::*;
#(
  parameter int UPSP_DATA_WIDTH = AC_UPSP_DATA_WIDTH,
  parameter int AXIS_DATA_WIDTH = AC_AXIS_DATA_WIDTH,
  parameter int FIFO_DEPTH      = AC_FIFO_DEPTH,
  parameter int GEOM_WIDTH      = AC_GEOM_WIDTH
) (
  input  wire                   clk,
  input  wire                   rst_n,
  input  wire                   cfg_start,
  input  wire  [GEOM_WIDTH-1:0] cfg_line_pix,
  input  wire  [GEOM_WIDTH-1:0] cfg_lines,
  ac_axis_out_packer_if.master  bus,
  output logic                  busy,
  output logic                  interrupt_updone
`ifdef AC_OUT_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt
`endif
);

  localparam int PIX_PER_BEAT = AXIS_DATA_WIDTH / UPSP_DATA_WIDTH;
  localparam int BYTES_PP     = UPSP_DATA_WIDTH / 8;
  localparam int KEEP_W       = AXIS_DATA_WIDTH / 8;
  localparam int LANE_W       = ac_idx_width(PIX_PER_BEAT);
  localparam int CNT_W        = ac_idx_width(FIFO_DEPTH) + 1;
  localparam int BEAT_W       = AXIS_DATA_WIDTH + KEEP_W + 2;

  typedef struct packed {
    logic [AXIS_DATA_WIDTH-1:0] data;
    logic [KEEP_W-1:0]          keep;
    logic                       last;
    logic                       user;
  } beat_t;

  ac_out_state_e              r_state;
  logic [GEOM_WIDTH-1:0]      r_line_pix;
  logic [GEOM_WIDTH-1:0]      r_lines;
  logic [GEOM_WIDTH-1:0]      r_pix_cnt;
  logic [GEOM_WIDTH-1:0]      r_line_cnt;
  logic [LANE_W-1:0]          r_lane;
  logic [AXIS_DATA_WIDTH-1:0] r_pack_data;
  logic [KEEP_W-1:0]          r_pack_keep;
  logic                       r_first;
  logic                       r_irq;

  logic                       w_full;
  logic                       w_empty;
  logic [CNT_W-1:0]           w_count;
  logic                       w_wready;
  logic                       w_acc;
  logic                       w_line_end;
  logic                       w_frame_end;
  logic                       w_push;
  logic                       w_pop;
  logic [AXIS_DATA_WIDTH-1:0] w_merge_data;
  logic [KEEP_W-1:0]          w_merge_keep;
  beat_t                      w_push_beat;
  beat_t                      w_head;

  assign w_wready    = (r_state == AC_OUT_RUN) && !w_full;
  assign w_acc       = bus.upsp_ac_wrt && w_wready;
  assign w_line_end  = (r_pix_cnt == r_line_pix - GEOM_WIDTH'(1));
  assign w_frame_end = w_line_end && (r_line_cnt == r_lines - GEOM_WIDTH'(1));
  assign w_push      = w_acc && ((r_lane == LANE_W'(PIX_PER_BEAT - 1)) || w_line_end);
  assign w_pop       = !w_empty && bus.axis_tready;

  // The completing pixel bypasses the pack register straight into the FIFO.
  always_comb begin
    w_merge_data = r_pack_data;
    w_merge_keep = r_pack_keep;
    for (int i = 0; i < PIX_PER_BEAT; i++) begin
      if (r_lane == LANE_W'(i)) begin
        w_merge_data[i*UPSP_DATA_WIDTH +: UPSP_DATA_WIDTH] = bus.upsp_ac_wdata;
        w_merge_keep[i*BYTES_PP +: BYTES_PP]               = '1;
      end
    end
  end

  assign w_push_beat = '{data: w_merge_data, keep: w_merge_keep,
                         last: w_line_end,   user: r_first};

  ac_sync_fifo #(
    .WIDTH (BEAT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_push_beat),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= AC_OUT_IDLE;
      r_line_pix  <= '0;
      r_lines     <= '0;
      r_pix_cnt   <= '0;
      r_line_cnt  <= '0;
      r_lane      <= '0;
      r_pack_data <= '0;
      r_pack_keep <= '0;
      r_first     <= 1'b0;
      r_irq       <= 1'b0;
    end else begin
      r_irq <= 1'b0;
      case (r_state)
        AC_OUT_IDLE: begin
          if (cfg_start) begin
            r_line_pix  <= cfg_line_pix;
            r_lines     <= cfg_lines;
            r_pix_cnt   <= '0;
            r_line_cnt  <= '0;
            r_lane      <= '0;
            r_pack_data <= '0;
            r_pack_keep <= '0;
            r_first     <= 1'b1;
            // An empty frame completes immediately without streaming.
            if ((cfg_line_pix == '0) || (cfg_lines == '0)) begin
              r_irq <= 1'b1;
            end else begin
              r_state <= AC_OUT_RUN;
            end
          end
        end
        AC_OUT_RUN: begin
          if (w_acc) begin
            if (w_push) begin
              r_pack_data <= '0;
              r_pack_keep <= '0;
              r_lane      <= '0;
              r_first     <= 1'b0;
            end else begin
              r_pack_data <= w_merge_data;
              r_pack_keep <= w_merge_keep;
              r_lane      <= r_lane + LANE_W'(1);
            end
            if (w_line_end) begin
              r_pix_cnt  <= '0;
              r_line_cnt <= r_line_cnt + GEOM_WIDTH'(1);
            end else begin
              r_pix_cnt  <= r_pix_cnt + GEOM_WIDTH'(1);
            end
            if (w_frame_end) begin
              r_state <= AC_OUT_DRAIN;
            end
          end
        end
        AC_OUT_DRAIN: begin
          if (w_pop && (w_count == CNT_W'(1))) begin
            r_state <= AC_OUT_IDLE;
            r_irq   <= 1'b1;
          end
        end
        default: r_state <= AC_OUT_IDLE;
      endcase
    end
  end

  // Stream fields read as zero whenever no beat is presented.
  assign bus.ac_upsp_wready = w_wready;
  assign bus.axis_tvalid    = !w_empty;
  assign bus.axis_tdata     = w_empty ? '0 : w_head.data;
  assign bus.axis_tkeep     = w_empty ? '0 : w_head.keep;
  assign bus.axis_tlast     = !w_empty && w_head.last;
  assign bus.axis_user      = !w_empty && w_head.user;
  assign busy               = (r_state != AC_OUT_IDLE);
  assign interrupt_updone   = r_irq;

`ifdef AC_OUT_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if ((r_state == AC_OUT_IDLE) && cfg_start) begin
      r_stall_cnt <= '0;
    end else if (busy && !w_empty && !bus.axis_tready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ac_axis_out_packer.sv
// ----------------------------------------------------------------------------
// tb_ac_axis_out_packer : directed scoreboard bench, default and depth-4 DUTs
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_ac_axis_out_packer;

  localparam int DW = 32;
  localparam int AW = 128;
  localparam int KW = AW / 8;
  localparam int PPB = AW / DW;

  typedef struct packed {
    logic [AW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [15:0] cfg_line_pix = '0;
  logic [15:0] cfg_lines = '0;
  logic        sel4 = 1'b0;
  logic        wrt = 1'b0;
  logic        tready = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy0, busy4, irq0, irq4;
`ifdef AC_OUT_STALL_CNT_EN
  logic [31:0] stall0, stall4;
`endif

  always #5 clk = ~clk;

  ac_axis_out_packer_if #(.UPSP_DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW)) if0 ();
  ac_axis_out_packer_if #(.UPSP_DATA_WIDTH(DW), .AXIS_DATA_WIDTH(AW)) if4 ();

  assign if0.upsp_ac_wrt   = wrt & ~sel4;
  assign if0.upsp_ac_wdata = wdata;
  assign if0.axis_tready   = tready;
  assign if4.upsp_ac_wrt   = wrt & sel4;
  assign if4.upsp_ac_wdata = wdata;
  assign if4.axis_tready   = tready;

  ac_axis_out_packer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start        (cfg_start & ~sel4),
    .cfg_line_pix     (cfg_line_pix),
    .cfg_lines        (cfg_lines),
    .bus              (if0.master),
    .busy             (busy0),
    .interrupt_updone (irq0)
`ifdef AC_OUT_STALL_CNT_EN
    ,
    .stall_cnt        (stall0)
`endif
  );

  ac_axis_out_packer #(.FIFO_DEPTH(4)) dut4 (
    .clk              (clk),
    .rst_n            (rst_n),
    .cfg_start        (cfg_start & sel4),
    .cfg_line_pix     (cfg_line_pix),
    .cfg_lines        (cfg_lines),
    .bus              (if4.master),
    .busy             (busy4),
    .interrupt_updone (irq4)
`ifdef AC_OUT_STALL_CNT_EN
    ,
    .stall_cnt        (stall4)
`endif
  );

  wire          m_wready = sel4 ? if4.ac_upsp_wready : if0.ac_upsp_wready;
  wire          m_tvalid = sel4 ? if4.axis_tvalid : if0.axis_tvalid;
  wire [AW-1:0] m_tdata  = sel4 ? if4.axis_tdata : if0.axis_tdata;
  wire [KW-1:0] m_tkeep  = sel4 ? if4.axis_tkeep : if0.axis_tkeep;
  wire          m_tlast  = sel4 ? if4.axis_tlast : if0.axis_tlast;
  wire          m_tuser  = sel4 ? if4.axis_user : if0.axis_user;
  wire          m_busy   = sel4 ? busy4 : busy0;
  wire          m_irq    = sel4 ? irq4 : irq0;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   hs_cyc = -10;
  int   n_beats = 0;
  exp_t sb[$];
  exp_t first_beat, last_beat, mon_e;

  logic [AW-1:0] md_data;
  logic [KW-1:0] md_keep;
  int            md_lane;
  logic          md_first;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Stream monitor: each handshake is popped against the scoreboard.
  always @(negedge clk) begin
    if (m_tvalid && tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("tdata", m_tdata, mon_e.data);
        chk("tkeep", m_tkeep, mon_e.keep);
        chk("tlast", m_tlast, mon_e.last);
        chk("tuser", m_tuser, mon_e.user);
      end
      last_beat = '{data: m_tdata, keep: m_tkeep, last: m_tlast, user: m_tuser};
      if (n_beats == 0) first_beat = last_beat;
      hs_cyc = cyc;
      n_beats++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start();
    md_data  = '0;
    md_keep  = '0;
    md_lane  = 0;
    md_first = 1'b1;
  endtask

  task automatic model_pix(input logic [31:0] v, input bit line_end);
    md_data[md_lane*DW +: DW] = v;
    md_keep[md_lane*4 +: 4]   = 4'hF;
    md_lane++;
    if (md_lane == PPB || line_end) begin
      sb.push_back('{data: md_data, keep: md_keep, last: line_end, user: md_first});
      md_data  = '0;
      md_keep  = '0;
      md_lane  = 0;
      md_first = 1'b0;
    end
  endtask

  task automatic put_pix(input logic [31:0] v, input bit line_end);
    int n;
    n = 0;
    wrt   = 1'b1;
    wdata = v;
    while (!m_wready && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) begin
      chk("wready_timeout", 0, 1);
    end else begin
      model_pix(v, line_end);
      step();
    end
  endtask

  task automatic start(input int lp, input int ln);
    cfg_line_pix = 16'(lp);
    cfg_lines    = 16'(ln);
    cfg_start    = 1'b1;
    step();
    cfg_start    = 1'b0;
    model_start();
    n_beats      = 0;
  endtask

  task automatic send_frame(input int lp, input int ln, input int base);
    for (int l = 0; l < ln; l++)
      for (int p = 0; p < lp; p++)
        put_pix(32'(base + l*lp + p), p == lp - 1);
    wrt = 1'b0;
  endtask

  task automatic wait_irq(input string tag);
    int n;
    n = 0;
    while (!m_irq && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_irq_seen"}, m_irq, 1);
    chk({tag, "_irq_latency"}, cyc, hs_cyc + 1);
    chk({tag, "_busy_at_irq"}, m_busy, 0);
    step();
    chk({tag, "_irq_pulse"}, m_irq, 0);
    chk({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_wready"}, m_wready, 0);
    chk({tag, "_tvalid"}, m_tvalid, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_irq"}, m_irq, 0);
    chk({tag, "_tdata"}, m_tdata, 0);
    chk({tag, "_tkeep"}, m_tkeep, 0);
    chk({tag, "_tlast"}, m_tlast, 0);
    chk({tag, "_tuser"}, m_tuser, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    // Two 8-pixel lines, full-width beats
    tready = 1'b1;
    start(8, 2);
    send_frame(8, 2, 0);
    wait_irq("t1");
    chk("t1_beats", n_beats, 4);
    chk("t1_beat0_data", first_beat.data, 128'h00000003_00000002_00000001_00000000);
    chk("t1_beat0_user", first_beat.user, 1);

    // One 6-pixel line: partial second beat
    start(6, 1);
    send_frame(6, 1, 100);
    wait_irq("t2");
    chk("t2_beats", n_beats, 2);
    chk("t2_last_keep", last_beat.keep, 16'h00FF);
    chk("t2_last_upper", last_beat.data[127:64], 0);
    chk("t2_last_tlast", last_beat.last, 1);

    // Depth-4 FIFO backpressure
    sel4   = 1'b1;
    tready = 1'b0;
    step();
    start(16, 2);
    for (int i = 0; i < 16; i++) put_pix(32'(200 + i), i == 15);
    wrt   = 1'b1;
    wdata = 32'd216;
    chk("t3_wready_full", m_wready, 0);
    chk("t3_tvalid_full", m_tvalid, 1);
    step();
    chk("t3_wready_held", m_wready, 0);
    tready = 1'b1;
    step();
    tready = 1'b0;
    chk("t3_wready_after_pop", m_wready, 1);
    tready = 1'b1;
    for (int i = 0; i < 16; i++) put_pix(32'(216 + i), i == 15);
    wrt = 1'b0;
    wait_irq("t3");
    chk("t3_beats", n_beats, 8);
    sel4 = 1'b0;
    step();

    // Empty frame
    cfg_line_pix = 16'd8;
    cfg_lines    = 16'd0;
    cfg_start    = 1'b1;
    step();
    cfg_start    = 1'b0;
    chk("t4_irq", m_irq, 1);
    chk("t4_busy", m_busy, 0);
    chk("t4_tvalid", m_tvalid, 0);
    step();
    chk("t4_irq_pulse", m_irq, 0);
    chk("t4_busy_after", m_busy, 0);

    // cfg_start during RUN is ignored
    start(4, 1);
    put_pix(32'd300, 0);
    put_pix(32'd301, 0);
    wrt          = 1'b0;
    cfg_line_pix = 16'd2;
    cfg_lines    = 16'd3;
    cfg_start    = 1'b1;
    step();
    cfg_start    = 1'b0;
    chk("t4b_busy", m_busy, 1);
    put_pix(32'd302, 0);
    put_pix(32'd303, 1);
    wrt = 1'b0;
    wait_irq("t4b");
    chk("t4b_beats", n_beats, 1);

    // Reset mid-frame, then a fresh single-beat frame
    tready = 1'b0;
    start(8, 1);
    for (int i = 0; i < 5; i++) put_pix(32'(400 + i), 0);
    wrt = 1'b0;
    chk("t5_tvalid_pre", m_tvalid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("t5_reset");
    sb.delete();
    step();
    step();
    rst_n  = 1'b1;
    step();
    tready = 1'b1;
    start(4, 1);
    send_frame(4, 1, 500);
    wait_irq("t5");
    chk("t5_beats", n_beats, 1);
    chk("t5_user", last_beat.user, 1);
    chk("t5_last", last_beat.last, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ac_axis_out_packer.md
Name: ac_axis_out_packer

Overview:
- Output-side data path of the access-control unit.
- Accepts single pixels from the up-sampling core's write port (upsp_ac_wrt / ac_upsp_wready / upsp_ac_wdata) and packs PIX_PER_BEAT pixels into each AXI-Stream master beat.
- Buffers beats in a FIFO, frames them with tuser (start of frame) and tlast (end of line), and raises interrupt_updone when a whole frame has left on the stream.
- Successor to the fixed 32-bit, one-pixel-per-beat output path: stream width, FIFO depth and frame geometry are all configurable.

Parameters:
- UPSP_DATA_WIDTH, 32: pixel width in bits. Must be a multiple of 8.
- AXIS_DATA_WIDTH, 128: stream data width. Must be an integer multiple of UPSP_DATA_WIDTH.
- PIX_PER_BEAT, AXIS_DATA_WIDTH/UPSP_DATA_WIDTH: derived, not overridable.
- FIFO_DEPTH, 8: beat FIFO entries. Power of two, at least 2.
- GEOM_WIDTH, 16: width of the line-length and line-count configuration fields.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- cfg_start  in  1  one-cycle pulse that starts a frame.
- cfg_line_pix  in  GEOM_WIDTH  pixels per line. Sampled when cfg_start is accepted.
- cfg_lines  in  GEOM_WIDTH  lines per frame. Sampled when cfg_start is accepted.
- upsp_ac_wrt  in  1  pixel valid from the up-sampling core.
- upsp_ac_wdata  in  UPSP_DATA_WIDTH  pixel data.
- ac_upsp_wready  out  1  pixel accept.
- axis_tvalid  out  1  stream master valid.
- axis_tready  in  1  stream master ready.
- axis_tdata  out  AXIS_DATA_WIDTH  packed pixels.
- axis_tkeep  out  AXIS_DATA_WIDTH/8  byte-valid mask.
- axis_tlast  out  1  last beat of a line.
- axis_user  out  1  first beat of a frame.
- busy  out  1  high in RUN or DRAIN.
- interrupt_updone  out  1  one-cycle frame-done pulse.

Behaviour:
- Reset (asynchronous assert):
  - All outputs go to 0.
  - FSM goes to IDLE; the FIFO, pack register and counters are cleared.
  - A reset mid-frame discards all buffered pixels and beats. No interrupt is issued.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - ac_upsp_wready = 0.
  - On cfg_start, latch cfg_line_pix and cfg_lines, clear the counters and go to RUN.
  - If either latched value is 0, stay in IDLE and pulse interrupt_updone in the next cycle (empty frame).
- RUN / DRAIN:
  - cfg_start is ignored in both states.
  - ac_upsp_wready = (state==RUN) && !fifo_full. It is combinational from registered state.
  - A pixel is accepted when upsp_ac_wrt && ac_upsp_wready.
  - The lane counter selects the lane. Pixel 0 of a beat goes in the LSBs, lane i occupies bits [i*UPSP_DATA_WIDTH +: UPSP_DATA_WIDTH].
- Beat completion:
  - A beat completes on the cycle its lane-(PIX_PER_BEAT-1) pixel is accepted, or the cycle the last pixel of a line is accepted.
  - The completed beat is pushed into the FIFO on that clock edge. The push data is the pack register merged with the incoming pixel.
  - Unfilled lanes carry zero data and zero tkeep bytes.
  - Beats never span lines. The lane counter resets at each line end.
- Beat tags:
  - tlast is set on a line's final beat.
  - tuser is set on the frame's first beat only.
- FIFO:
  - First-word fall-through. axis_tvalid = !fifo_empty.
  - axis_tvalid first rises the cycle after the completing pixel is accepted (latency 1).
  - Pop on axis_tvalid && axis_tready.
  - Push and pop in the same cycle are legal at any occupancy below full. Count is unchanged.
  - When full, wready is low; a pop in that cycle raises wready in the next cycle.
  - tdata, tkeep, tlast and tuser are held stable while tvalid && !tready.
- Counters:
  - Pixel-in-line counter of GEOM_WIDTH bits; line counter of GEOM_WIDTH bits.
  - Both compare against the latched config using equality with value-1. No wrap-around beyond the config is possible.
- RUN to DRAIN: on acceptance of the frame's final pixel.
- DRAIN to IDLE:
  - Exit occurs when the FIFO goes empty via a pop.
  - interrupt_updone pulses in the cycle after the final beat's handshake, simultaneous with the return to IDLE.
  - busy falls in the same cycle.
- A cfg_start coincident with that interrupt cycle is accepted.

Optional Feature:
- Macro: AC_OUT_STALL_CNT_EN.
- Defined:
  - Adds output port stall_cnt [31:0].
  - Counts cycles with axis_tvalid && !axis_tready while busy.
  - Cleared on accepted cfg_start and on reset; saturates at all-ones.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package ac_pkg holds:
  - the FSM state enum (AC_OUT_IDLE, AC_OUT_RUN, AC_OUT_DRAIN);
  - the beat struct {data, keep, last, user};
  - the default width localparams shared with the input path.
- One sub-module: ac_sync_fifo.
  - Parametrised width and depth; first-word fall-through.
  - full/empty flags and a count output.
  - Reused by the input path.

Test Plan:
- Defaults; line 8 px, 2 lines, pixels 0..15, tready=1 -> 4 beats:
  - beat0 tdata=0x00000003_00000002_00000001_00000000, axis_user=1;
  - tlast on beats 1 and 3;
  - tkeep=16'hFFFF on all beats;
  - interrupt_updone one cycle after the beat3 handshake.
- Line 6 px, 1 line -> 2 beats:
  - beat1 tkeep=16'h00FF, upper 64 bits of tdata zero, tlast=1.
- FIFO_DEPTH 4, tready=0, 16 px offered continuously -> wready falls after 16 px (4 beats); no beat lost.
- Same FIFO_DEPTH 4 case, then tready pulsed once -> wready high again the next cycle; beat order preserved.
- cfg_lines=0 -> no beats; interrupt_updone pulses the cycle after cfg_start; busy stays 0. A second cfg_start during RUN is ignored, so frame geometry is unchanged.
- rst_n low after 5 of 8 px -> all outputs 0 immediately. A new cfg_start with line 4, 1 line yields exactly 1 beat with tuser=1 and tlast=1.
